stream_width_packer: RTL and testbench

- Reader-side companion to the interleaved sync FIFO: consumes the FIFO's narrow valid/ready output stream and packs PACK_RATIO beats into one wide word for downstream wide datapaths.
- Supports early termination via in_last, which emits a partial word with a byte-lane keep mask.
- Single output register; full throughput of one input beat per cycle when downstream is ready.

---
 rtl/stream_width_packer_pkg.sv | 20 ++
 rtl/stream_width_packer_if.sv | 28 ++
 rtl/stream_width_packer_accumulator.sv | 53 +++++
 rtl/stream_width_packer.sv | 80 ++++++++
 tb/tb_stream_width_packer.sv | 187 ++++++++++++++++++
 5 files changed

// File: rtl/stream_width_packer_pkg.sv
// Shared types, default geometry and keep-mask helper for the stream width packer.
package stream_pack_pkg;

  localparam int DATA_WIDTH_DEF = 8;
  localparam int PACK_RATIO_DEF = 4;
  localparam int OUT_WIDTH      = DATA_WIDTH_DEF * PACK_RATIO_DEF;
  localparam int FILL_WIDTH     = $clog2(PACK_RATIO_DEF) + 1;

  typedef enum logic {
    FILL = 1'b0,
    HOLD = 1'b1
  } pack_state_e;

  // Contiguous low-lane mask with n lanes set; callers truncate to PACK_RATIO bits.
  function automatic logic [31:0] keep_from_count(input int unsigned n);
    if (n >= 32) return '1;
    return (32'd1 << n) - 32'd1;
  endfunction

endpackage

// File: rtl/stream_width_packer_if.sv
// Narrow-in / wide-out stream bundle between the packer and its neighbours.
interface stream_pack_if #(
  parameter int DATA_WIDTH = 8,
  parameter int PACK_RATIO = 4
);

  logic [DATA_WIDTH-1:0]            in_data;
  logic                             in_valid;
  logic                             in_last;
  logic                             in_ready;
  logic [DATA_WIDTH*PACK_RATIO-1:0] out_data;
  logic [PACK_RATIO-1:0]            out_keep;
  logic                             out_last;
  logic                             out_valid;
  logic                             out_ready;
  logic [$clog2(PACK_RATIO):0]      fill;

  modport slave (
    input  in_data, in_valid, in_last, out_ready,
    output in_ready, out_data, out_keep, out_last, out_valid, fill
  );

  modport master (
    output in_data, in_valid, in_last, out_ready,
    input  in_ready, out_data, out_keep, out_last, out_valid, fill
  );

endinterface

// File: rtl/stream_width_packer_accumulator.sv
// Lane registers and fill counter; presents the word as it would look with the current beat merged in.
module pack_accumulator
  import stream_pack_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int PACK_RATIO = PACK_RATIO_DEF
) (
  input  logic                             clk,
  input  logic                             flush,
  input  logic                             wr_en,
  input  logic                             emit,
  input  logic [DATA_WIDTH-1:0]            wr_data,
  output logic [DATA_WIDTH*PACK_RATIO-1:0] word,
  output logic [$clog2(PACK_RATIO):0]      fill,
  output logic                             at_last_lane
);

  localparam int OUT_W  = DATA_WIDTH * PACK_RATIO;
  localparam int FILL_W = $clog2(PACK_RATIO) + 1;

  logic [OUT_W-1:0]  lanes_p0;
  logic [FILL_W-1:0] fill_p0;

  // Write-lane decode: the incoming beat overlays the lane selected by fill.
  always_comb begin
    word = lanes_p0;
    for (int k = 0; k < PACK_RATIO; k++) begin
      if (wr_en && (fill_p0 == FILL_W'(k))) begin
        word[k*DATA_WIDTH +: DATA_WIDTH] = wr_data;
      end
    end
  end

  assign at_last_lane = (fill_p0 == FILL_W'(PACK_RATIO - 1));
  assign fill         = fill_p0;

  // Stage p0: accumulator; emptied whenever its contents move to the output register.
  always_ff @(posedge clk) begin
    if (flush) begin
      lanes_p0 <= '0;
      fill_p0  <= '0;
    end else if (wr_en) begin
      if (emit) begin
        lanes_p0 <= '0;
        fill_p0  <= '0;
      end else begin
        lanes_p0 <= word;
        fill_p0  <= fill_p0 + FILL_W'(1);
      end
    end
  end

endmodule

// File: rtl/stream_width_packer.sv
// Packs PACK_RATIO narrow beats (or a shorter in_last-terminated run) into one wide keep-masked word.
module stream_width_packer
  import stream_pack_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int PACK_RATIO = PACK_RATIO_DEF
) (
  input logic          clk,
  input logic          rst,
  input logic          clear,
  stream_pack_if.slave s
);

  localparam int OUT_W  = DATA_WIDTH * PACK_RATIO;
  localparam int FILL_W = $clog2(PACK_RATIO) + 1;

  logic              flush;
  logic              accept;
  logic              emit;
  logic [OUT_W-1:0]  acc_word;
  logic [FILL_W-1:0] acc_fill;
  logic              acc_at_last;

  pack_state_e           state_p1;
  logic [OUT_W-1:0]      data_p1;
  logic [PACK_RATIO-1:0] keep_p1;
  logic                  last_p1;

  assign flush = rst || clear;

  // A held word blocks input unless it drains this same cycle, so no bubble on drain.
  assign s.in_ready = !flush && ((state_p1 == FILL) || s.out_ready);
  assign accept     = s.in_valid && s.in_ready;
  assign emit       = accept && (s.in_last || acc_at_last);

  pack_accumulator #(
    .DATA_WIDTH (DATA_WIDTH),
    .PACK_RATIO (PACK_RATIO)
  ) u_acc (
    .clk          (clk),
    .flush        (flush),
    .wr_en        (accept),
    .emit         (emit),
    .wr_data      (s.in_data),
    .word         (acc_word),
    .fill         (acc_fill),
    .at_last_lane (acc_at_last)
  );

  // Stage p1: output register; only an emit may overwrite it, and only when it is free or draining.
  always_ff @(posedge clk) begin
    if (flush) begin
      state_p1 <= FILL;
      data_p1  <= '0;
      keep_p1  <= '0;
      last_p1  <= 1'b0;
    end else if (emit) begin
      state_p1 <= HOLD;
      data_p1  <= acc_word;
      keep_p1  <= PACK_RATIO'(keep_from_count(32'(acc_fill) + 32'd1));
      last_p1  <= s.in_last;
    end else if ((state_p1 == HOLD) && s.out_ready) begin
      state_p1 <= FILL;
    end
  end

  assign s.out_valid = (state_p1 == HOLD);
  assign s.out_data  = data_p1;
  assign s.out_keep  = keep_p1;
  assign s.out_last  = last_p1;
  assign s.fill      = acc_fill;

  a_hold_stable: assert property (@(posedge clk) disable iff (flush)
    (s.out_valid && !s.out_ready) |=> (s.out_valid && $stable(s.out_data)
                                       && $stable(s.out_keep) && $stable(s.out_last)));

  a_fill_range: assert property (@(posedge clk) disable iff (flush)
    (acc_fill < FILL_W'(PACK_RATIO)));

endmodule

// File: tb/tb_stream_width_packer.sv
// Directed bench for stream_width_packer: vector table plus reset, backpressure and clear sequences.
module tb_stream_width_packer;
  import stream_pack_pkg::*;

  logic clk;
  logic rst;
  logic clear;

  int n_checks;
  int n_fail;

  stream_pack_if #(.DATA_WIDTH(8), .PACK_RATIO(4)) bus ();

  stream_width_packer #(.DATA_WIDTH(8), .PACK_RATIO(4)) dut (
    .clk   (clk),
    .rst   (rst),
    .clear (clear),
    .s     (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        v;
    logic [7:0]  d;
    logic        l;
    logic        r;
    logic        exp_ir;
    logic        exp_ov;
    logic [31:0] exp_data;
    logic [3:0]  exp_keep;
    logic        exp_last;
    logic [2:0]  exp_fill;
  } vec_t;

  vec_t vecs[26];

  function automatic vec_t mk(input logic v, input logic [7:0] d, input logic l,
                              input logic ov, input logic [31:0] data,
                              input logic [3:0] keep, input logic last,
                              input logic [2:0] fill);
    vec_t t;
    t.v = v; t.d = d; t.l = l; t.r = 1'b1; t.exp_ir = 1'b1;
    t.exp_ov = ov; t.exp_data = data; t.exp_keep = keep;
    t.exp_last = last; t.exp_fill = fill;
    return t;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drive one cycle's inputs after the falling edge, then settle before checking.
  task automatic step(input logic v, input logic [7:0] d, input logic l,
                      input logic r, input logic c);
    @(negedge clk);
    bus.in_valid  = v;
    bus.in_data   = d;
    bus.in_last   = l;
    bus.out_ready = r;
    clear         = c;
    #1;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst = 1'b1;
    clear = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data = '0;
    bus.in_last = 1'b0;
    bus.out_ready = 1'b1;

    // Vectors checked before the edge that samples their inputs.
    vecs[0]  = mk(1, 8'h11, 0, 0, 32'h0,        4'h0, 0, 3'd0);
    vecs[1]  = mk(1, 8'h22, 0, 0, 32'h0,        4'h0, 0, 3'd1);
    vecs[2]  = mk(1, 8'h33, 0, 0, 32'h0,        4'h0, 0, 3'd2);
    vecs[3]  = mk(1, 8'h44, 0, 0, 32'h0,        4'h0, 0, 3'd3);
    vecs[4]  = mk(0, 8'h00, 0, 1, 32'h44332211, 4'hF, 0, 3'd0);
    vecs[5]  = mk(1, 8'hAA, 0, 0, 32'h0,        4'h0, 0, 3'd0);
    vecs[6]  = mk(1, 8'hBB, 1, 0, 32'h0,        4'h0, 0, 3'd1);
    vecs[7]  = mk(0, 8'h00, 0, 1, 32'h0000BBAA, 4'h3, 1, 3'd0);
    vecs[8]  = mk(1, 8'h01, 0, 0, 32'h0,        4'h0, 0, 3'd0);
    vecs[9]  = mk(1, 8'h02, 0, 0, 32'h0,        4'h0, 0, 3'd1);
    vecs[10] = mk(1, 8'h03, 0, 0, 32'h0,        4'h0, 0, 3'd2);
    vecs[11] = mk(1, 8'h04, 0, 0, 32'h0,        4'h0, 0, 3'd3);
    vecs[12] = mk(1, 8'h05, 0, 1, 32'h04030201, 4'hF, 0, 3'd0);
    vecs[13] = mk(1, 8'h06, 0, 0, 32'h0,        4'h0, 0, 3'd1);
    vecs[14] = mk(1, 8'h07, 0, 0, 32'h0,        4'h0, 0, 3'd2);
    vecs[15] = mk(1, 8'h08, 0, 0, 32'h0,        4'h0, 0, 3'd3);
    vecs[16] = mk(0, 8'h00, 0, 1, 32'h08070605, 4'hF, 0, 3'd0);
    vecs[17] = mk(1, 8'h5A, 1, 0, 32'h0,        4'h0, 0, 3'd0);
    vecs[18] = mk(0, 8'h00, 0, 1, 32'h0000005A, 4'h1, 1, 3'd0);
    vecs[19] = mk(1, 8'hC1, 0, 0, 32'h0,        4'h0, 0, 3'd0);
    vecs[20] = mk(1, 8'hC2, 0, 0, 32'h0,        4'h0, 0, 3'd1);
    vecs[21] = mk(1, 8'hC3, 0, 0, 32'h0,        4'h0, 0, 3'd2);
    vecs[22] = mk(1, 8'hC4, 1, 0, 32'h0,        4'h0, 0, 3'd3);
    vecs[23] = mk(1, 8'hD1, 1, 1, 32'hC4C3C2C1, 4'hF, 1, 3'd0);
    vecs[24] = mk(0, 8'h00, 0, 1, 32'h000000D1, 4'h1, 1, 3'd0);
    vecs[25] = mk(0, 8'h00, 0, 0, 32'h0,        4'h0, 0, 3'd0);

    // Reset held for 10 cycles with a beat offered.
    bus.in_valid = 1'b1;
    bus.in_data  = 8'hEE;
    repeat (10) @(negedge clk);
    #1;
    chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    bus.in_valid = 1'b0;
    #1;
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_fill",      32'(bus.fill),      32'd0);
    chk("rst_in_ready",  32'(bus.in_ready),  32'd1);
    chk("rst_out_data",  bus.out_data,       32'd0);
    chk("rst_out_keep",  32'(bus.out_keep),  32'd0);
    chk("rst_out_last",  32'(bus.out_last),  32'd0);

    for (int i = 0; i < 26; i++) begin
      step(vecs[i].v, vecs[i].d, vecs[i].l, vecs[i].r, 1'b0);
      chk($sformatf("vec%0d_in_ready", i),  32'(bus.in_ready),  32'(vecs[i].exp_ir));
      chk($sformatf("vec%0d_out_valid", i), 32'(bus.out_valid), 32'(vecs[i].exp_ov));
      chk($sformatf("vec%0d_fill", i),      32'(bus.fill),      32'(vecs[i].exp_fill));
      if (vecs[i].exp_ov) begin
        chk($sformatf("vec%0d_out_data", i), bus.out_data,      vecs[i].exp_data);
        chk($sformatf("vec%0d_out_keep", i), 32'(bus.out_keep), 32'(vecs[i].exp_keep));
        chk($sformatf("vec%0d_out_last", i), 32'(bus.out_last), 32'(vecs[i].exp_last));
      end
    end

    // Backpressure: word 0x04030201 stalls with 0x05 offered.
    for (int b = 1; b <= 4; b++) step(1'b1, 8'(b), 1'b0, 1'b1, 1'b0);
    for (int h = 0; h < 5; h++) begin
      step(1'b1, 8'h05, 1'b0, 1'b0, 1'b0);
      chk($sformatf("bp%0d_in_ready", h),  32'(bus.in_ready),  32'd0);
      chk($sformatf("bp%0d_out_valid", h), 32'(bus.out_valid), 32'd1);
      chk($sformatf("bp%0d_out_data", h),  bus.out_data,       32'h04030201);
      chk($sformatf("bp%0d_out_keep", h),  32'(bus.out_keep),  32'hF);
      chk($sformatf("bp%0d_fill", h),      32'(bus.fill),      32'd0);
    end
    step(1'b1, 8'h05, 1'b0, 1'b1, 1'b0);
    chk("bp_release_in_ready", 32'(bus.in_ready), 32'd1);
    step(1'b1, 8'h06, 1'b1, 1'b1, 1'b0);
    chk("bp_after_out_valid", 32'(bus.out_valid), 32'd0);
    chk("bp_after_fill",      32'(bus.fill),      32'd1);
    step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    chk("bp_tail_out_data", bus.out_data,      32'h00000605);
    chk("bp_tail_out_keep", 32'(bus.out_keep), 32'h3);

    // Clear mid-fill discards 0x10,0x20.
    step(1'b1, 8'h10, 1'b0, 1'b1, 1'b0);
    step(1'b1, 8'h20, 1'b0, 1'b1, 1'b0);
    step(1'b1, 8'h99, 1'b0, 1'b1, 1'b1);
    chk("clr_in_ready", 32'(bus.in_ready), 32'd0);
    chk("clr_fill_before", 32'(bus.fill), 32'd2);
    for (int b = 0; b < 4; b++) begin
      step(1'b1, 8'(8'h30 + 8'(b * 16)), 1'b0, 1'b1, 1'b0);
      chk($sformatf("clr_beat%0d_out_valid", b), 32'(bus.out_valid), 32'd0);
      chk($sformatf("clr_beat%0d_fill", b),      32'(bus.fill),      32'(b));
    end
    step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    chk("clr_word_out_valid", 32'(bus.out_valid), 32'd1);
    chk("clr_word_out_data",  bus.out_data,       32'h60504030);
    chk("clr_word_fill",      32'(bus.fill),      32'd0);

    // Clear while a word is stalled in the output register.
    for (int b = 0; b < 4; b++) step(1'b1, 8'(8'h71 + 8'(b)), 1'b0, 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    chk("hold_out_data", bus.out_data, 32'h74737271);
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    chk("hold_clr_out_valid", 32'(bus.out_valid), 32'd0);
    chk("hold_clr_out_data",  bus.out_data,       32'd0);
    chk("hold_clr_out_keep",  32'(bus.out_keep),  32'd0);
    chk("hold_clr_in_ready",  32'(bus.in_ready),  32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
